// File: rtl/mem_bus_pkg.sv
// Shared constants and state encoding for the memory bus arbiter.
package mem_bus_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ID_W    = $clog2(NUM_REQ);

    // Requester slots on the shared interconnect
    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DCACHE = 1;
    localparam int unsigned REQ_IO     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester/memory side signals of the shared memory bus.
// master: requesters plus memory return path; slave: the arbiter.
interface mem_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_rd_wr;
    logic [NUM_REQ-1:0]        req_en;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ADDR_W-1:0]         bus_addr;
    logic                      bus_rd_wr;
    logic                      bus_en;
    logic                      bus_data_valid;
    logic                      bus_busy;
    logic [ID_W-1:0]           owner_id;
    logic                      timeout_err;

    modport master (
        output req, done, req_addr, req_rd_wr, req_en, bus_data_valid,
        input  grant, rsp_valid, bus_addr, bus_rd_wr, bus_en, bus_busy, owner_id, timeout_err
    );

    modport slave (
        input  req, done, req_addr, req_rd_wr, req_en, bus_data_valid,
        output grant, rsp_valid, bus_addr, bus_rd_wr, bus_en, bus_busy, owner_id, timeout_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    int unsigned idx;

    // Scan NUM_REQ slots starting at rr_ptr; the first hit wins
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx[ID_W-1:0]]) begin
                any                        = 1'b1;
                gnt_id                     = idx[ID_W-1:0];
                gnt_onehot[idx[ID_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory interconnect. One requester holds the bus
// for a whole line transfer; its command is muxed out and return beats go to it only.
// A hold watchdog forces a hung owner off the bus.
module mem_bus_arbiter #(
    parameter int unsigned NUM_REQ  = mem_bus_pkg::NUM_REQ,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_HOLD = 64
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    import mem_bus_pkg::*;

    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_RAW   = $clog2(MAX_HOLD + 1);
    localparam int unsigned CNT_W     = (CNT_RAW > 0) ? CNT_RAW : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               timeout_q, timeout_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_wr_q, rd_wr_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;

    logic [ADDR_W-1:0]  own_addr;
    logic               own_rd_wr;
    logic               own_en;
    logic               own_req;
    logic               own_done;
    logic               wd_hit;
    logic [ID_W-1:0]    next_ptr;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_pick (
        .req       (bus.req),
        .rr_ptr    (rr_ptr_q),
        .gnt_onehot(pick_onehot),
        .gnt_id    (pick_id),
        .any       (pick_any)
    );

    // Select the current owner's command and handshake lines
    always_comb begin
        own_addr  = '0;
        own_rd_wr = 1'b0;
        own_en    = 1'b0;
        own_req   = 1'b0;
        own_done  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                own_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_rd_wr = bus.req_rd_wr[i];
                own_en    = bus.req_en[i];
                own_req   = bus.req[i];
                own_done  = bus.done[i];
            end
        end
    end

    assign wd_hit   = (MAX_HOLD != 0) && (hold_q == CNT_W'(HOLD_LAST));
    // Owner drops to lowest priority for the next arbitration
    assign next_ptr = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // Next-state logic: arbitration, hold watchdog and release bookkeeping
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        addr_d    = addr_q;
        rd_wr_d   = rd_wr_q;
        unique case (state_q)
            IDLE, RELEASE: begin
                grant_d = '0;
                hold_d  = '0;
                if (pick_any) begin
                    grant_d = pick_onehot;
                    owner_d = pick_id;
                    state_d = OWNED;
                end else begin
                    state_d = IDLE;
                end
            end
            OWNED: begin
                addr_d  = own_addr;
                rd_wr_d = own_rd_wr;
                hold_d  = hold_q + CNT_W'(1);
                // done and abandon take precedence over the watchdog
                if (own_done || !own_req || wd_hit) begin
                    timeout_d = !own_done && own_req;
                    state_d   = RELEASE;
                    grant_d   = '0;
                    hold_d    = '0;
                    rr_ptr_d  = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            rd_wr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            rd_wr_q   <= rd_wr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.rsp_valid   = grant_q & {NUM_REQ{bus.bus_data_valid}};
    assign bus.bus_addr    = (state_q == OWNED) ? own_addr : addr_q;
    assign bus.bus_rd_wr   = (state_q == OWNED) ? own_rd_wr : rd_wr_q;
    assign bus.bus_en      = (state_q == OWNED) && own_en;
    assign bus.bus_busy    = (state_q == OWNED);
    assign bus.owner_id    = owner_q;
    assign bus.timeout_err = timeout_q;

endmodule
